// File: rtl/sfifo_mchan_pkg.sv
// Shared types and helpers for the multi-channel FIFO (sfifo_mchan_par).
// Optional partial-full feature is selected by the macro SFIFO_MCHAN_PFULL_EN.
package sfifo_mchan_pkg;

   localparam int unsigned WIDTH_DEF       = 16;
   localparam int unsigned DEPTH_NBITS_DEF = 3;
   localparam int unsigned NCH_DEF         = 4;
   localparam int unsigned CH_NBITS_DEF    = 2;

   typedef logic [CH_NBITS_DEF-1:0]  ch_idx_t;
   typedef logic [DEPTH_NBITS_DEF-1:0] ptr_t;
   typedef logic [DEPTH_NBITS_DEF:0]   cnt_t;

   // Extracts channel c's occupancy from the packed count bus.
   function automatic cnt_t cnt_slice(input logic [NCH_DEF*(DEPTH_NBITS_DEF+1)-1:0] count,
                                      input int unsigned c);
      return count[c*(DEPTH_NBITS_DEF+1) +: (DEPTH_NBITS_DEF+1)];
   endfunction

endpackage

// File: rtl/sfifo_mchan_ctrl.sv
// Per-channel pointer/occupancy tracker; flush has priority over accepted wr/rd.
// Partial-full threshold compare is built only with SFIFO_MCHAN_PFULL_EN.
module sfifo_mchan_ctrl
   import sfifo_mchan_pkg::*;
#(
   parameter int unsigned DEPTH_NBITS = DEPTH_NBITS_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   acc_wr_i,
   input  logic                   acc_rd_i,
   input  logic                   flush_i,
`ifdef SFIFO_MCHAN_PFULL_EN
   input  logic [DEPTH_NBITS:0]   pfull_th_i,
   output logic                   pfull_o,
`endif
   output logic [DEPTH_NBITS-1:0] rptr_o,
   output logic [DEPTH_NBITS-1:0] wptr_o,
   output logic [DEPTH_NBITS:0]   count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_NBITS;
   localparam logic [DEPTH_NBITS:0] FULL_CNT = DEPTH[DEPTH_NBITS:0];

   logic [DEPTH_NBITS-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [DEPTH_NBITS:0]   count_q, count_d;
   logic                   full_q, full_d, empty_q, empty_d;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (acc_wr_i) wptr_d = wptr_q + 1'b1;
         if (acc_rd_i) rptr_d = rptr_q + 1'b1;
         case ({acc_wr_i, acc_rd_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
      full_d  = (count_d == FULL_CNT);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

`ifdef SFIFO_MCHAN_PFULL_EN
   logic pfull_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) pfull_q <= 1'b0;
      else       pfull_q <= (count_d >= pfull_th_i);
   end

   assign pfull_o = pfull_q;
`endif

   assign rptr_o  = rptr_q;
   assign wptr_o  = wptr_q;
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/sfifo_mchan_par.sv
// Multi-channel synchronous FIFO: NCH queues in one shared array, 1-cycle registered read.
// Optional per-channel partial-full flags are enabled by SFIFO_MCHAN_PFULL_EN.
module sfifo_mchan_par
   import sfifo_mchan_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEF,
   parameter int unsigned DEPTH_NBITS = DEPTH_NBITS_DEF,
   parameter int unsigned NCH         = NCH_DEF,
   parameter int unsigned CH_NBITS    = CH_NBITS_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_i,
   input  logic [CH_NBITS-1:0]          wr_ch_i,
   input  logic [WIDTH-1:0]             din_i,
   input  logic                         rd_i,
   input  logic [CH_NBITS-1:0]          rd_ch_i,
   input  logic [NCH-1:0]               flush_i,
`ifdef SFIFO_MCHAN_PFULL_EN
   input  logic [DEPTH_NBITS:0]         pfull_th_i,
   output logic [NCH-1:0]               pfull_o,
`endif
   output logic [WIDTH-1:0]             dout_o,
   output logic                         dout_vld_o,
   output logic [CH_NBITS-1:0]          dout_ch_o,
   output logic [NCH-1:0]               full_o,
   output logic [NCH-1:0]               empty_o,
   output logic [NCH*(DEPTH_NBITS+1)-1:0] count_o,
   output logic                         ovf_o,
   output logic                         udf_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_NBITS;

   logic [DEPTH_NBITS-1:0] rptr_w [NCH];
   logic [DEPTH_NBITS-1:0] wptr_w [NCH];
   logic [NCH-1:0]         full_w, empty_w;

   logic acc_wr, acc_rd, ovf_d, udf_d;
   logic [CH_NBITS+DEPTH_NBITS-1:0] wr_addr, rd_addr;

   // Flush on the addressed channel swallows the request without raising ovf/udf.
   assign acc_wr = ~rst_i & wr_i & ~full_w[wr_ch_i]  & ~flush_i[wr_ch_i];
   assign acc_rd = ~rst_i & rd_i & ~empty_w[rd_ch_i] & ~flush_i[rd_ch_i];
   assign ovf_d  = wr_i & full_w[wr_ch_i]  & ~flush_i[wr_ch_i];
   assign udf_d  = rd_i & empty_w[rd_ch_i] & ~flush_i[rd_ch_i];

   assign wr_addr = {wr_ch_i, wptr_w[wr_ch_i]};
   assign rd_addr = {rd_ch_i, rptr_w[rd_ch_i]};

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      sfifo_mchan_ctrl #(.DEPTH_NBITS(DEPTH_NBITS)) u_ctrl (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .acc_wr_i (acc_wr & (wr_ch_i == CH_NBITS'(c))),
         .acc_rd_i (acc_rd & (rd_ch_i == CH_NBITS'(c))),
         .flush_i  (flush_i[c]),
`ifdef SFIFO_MCHAN_PFULL_EN
         .pfull_th_i (pfull_th_i),
         .pfull_o    (pfull_o[c]),
`endif
         .rptr_o   (rptr_w[c]),
         .wptr_o   (wptr_w[c]),
         .count_o  (count_o[c*(DEPTH_NBITS+1) +: (DEPTH_NBITS+1)]),
         .full_o   (full_w[c]),
         .empty_o  (empty_w[c])
      );
   end

   logic [WIDTH-1:0] mem_q [NCH*DEPTH];

   always_ff @(posedge clk_i) begin
      if (acc_wr) mem_q[wr_addr] <= din_i;
   end

   logic [WIDTH-1:0]    dout_q;
   logic [CH_NBITS-1:0] dout_ch_q;
   logic                dout_vld_q, ovf_q, udf_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dout_q     <= '0;
         dout_ch_q  <= '0;
         dout_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         dout_vld_q <= acc_rd;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         if (acc_rd) begin
            dout_q    <= mem_q[rd_addr];
            dout_ch_q <= rd_ch_i;
         end
      end
   end

   assign dout_o     = dout_q;
   assign dout_ch_o  = dout_ch_q;
   assign dout_vld_o = dout_vld_q;
   assign ovf_o      = ovf_q;
   assign udf_o      = udf_q;
   assign full_o     = full_w;
   assign empty_o    = empty_w;

endmodule

// File: tb/tb_sfifo_mchan_par.sv
// Directed bench for sfifo_mchan_par (NCH=4, DEPTH=8, WIDTH=16).
// Partial-full checks are included when SFIFO_MCHAN_PFULL_EN is defined.
module tb_sfifo_mchan_par;
   import sfifo_mchan_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wr_i;
   logic [1:0]  wr_ch_i;
   logic [15:0] din_i;
   logic        rd_i;
   logic [1:0]  rd_ch_i;
   logic [3:0]  flush_i;
   logic [15:0] dout_o;
   logic        dout_vld_o;
   logic [1:0]  dout_ch_o;
   logic [3:0]  full_o, empty_o;
   logic [15:0] count_o;
   logic        ovf_o, udf_o;
`ifdef SFIFO_MCHAN_PFULL_EN
   logic [3:0]  pfull_th_i;
   logic [3:0]  pfull_o;
`endif

   always #5 clk_i = ~clk_i;

   sfifo_mchan_par dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_i       (wr_i),
      .wr_ch_i    (wr_ch_i),
      .din_i      (din_i),
      .rd_i       (rd_i),
      .rd_ch_i    (rd_ch_i),
      .flush_i    (flush_i),
`ifdef SFIFO_MCHAN_PFULL_EN
      .pfull_th_i (pfull_th_i),
      .pfull_o    (pfull_o),
`endif
      .dout_o     (dout_o),
      .dout_vld_o (dout_vld_o),
      .dout_ch_o  (dout_ch_o),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .count_o    (count_o),
      .ovf_o      (ovf_o),
      .udf_o      (udf_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      wr_i    = 1'b0;
      rd_i    = 1'b0;
      flush_i = 4'b0000;
   endtask

   function automatic logic [31:0] cnt(input int unsigned c);
      return 32'(cnt_slice(count_o, c));
   endfunction

   initial begin
      rst_i = 1'b1; wr_ch_i = '0; rd_ch_i = '0; din_i = '0;
      idle();
`ifdef SFIFO_MCHAN_PFULL_EN
      pfull_th_i = 4'd6;
`endif
      tick(); tick();
      rst_i = 1'b0;
      tick();
      check("rst_empty", 32'(empty_o), 32'hF);
      check("rst_full",  32'(full_o), 32'h0);
      check("rst_count", 32'(count_o), 32'h0);
      check("rst_vld",   32'(dout_vld_o), 32'h0);
      check("rst_dout",  32'(dout_o), 32'h0);
      check("rst_ovf_udf", 32'({ovf_o, udf_o}), 32'h0);

      // fill ch2, then overflow
      for (int k = 1; k <= 8; k++) begin
         wr_i = 1'b1; wr_ch_i = 2'd2; din_i = 16'(k * 16'h1111);
         tick();
      end
      check("fill_full2",  32'(full_o[2]), 32'h1);
      check("fill_count2", cnt(2), 32'd8);
      check("fill_noovf",  32'(ovf_o), 32'h0);
      din_i = 16'h9999;
      tick();
      check("ovf_pulse",   32'(ovf_o), 32'h1);
      check("ovf_count2",  cnt(2), 32'd8);
      idle();
      tick();
      check("ovf_clear",   32'(ovf_o), 32'h0);

      // drain ch2 back-to-back
      rd_i = 1'b1; rd_ch_i = 2'd2;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("rd2_vld",  32'(dout_vld_o), 32'h1);
         check("rd2_data", 32'(dout_o), 32'(k * 16'h1111));
         check("rd2_ch",   32'(dout_ch_o), 32'd2);
      end
      check("rd2_empty", 32'(empty_o[2]), 32'h1);
      tick();
      check("udf_pulse", 32'(udf_o), 32'h1);
      check("udf_novld", 32'(dout_vld_o), 32'h0);
      check("udf_hold",  32'(dout_o), 32'h8888);
      idle();
      tick();
      check("udf_clear", 32'(udf_o), 32'h0);

      // interleave wr ch0 with rd ch1
      wr_i = 1'b1; wr_ch_i = 2'd1; din_i = 16'hAAAA;
      tick();
      wr_ch_i = 2'd0; din_i = 16'h0B0B; rd_i = 1'b1; rd_ch_i = 2'd1;
      tick();
      check("il_dout",   32'(dout_o), 32'hAAAA);
      check("il_vld",    32'(dout_vld_o), 32'h1);
      check("il_ch",     32'(dout_ch_o), 32'd1);
      check("il_count0", cnt(0), 32'd1);
      check("il_count1", cnt(1), 32'd0);
      idle();

      // ch3 preload 5 then 20 cycles of concurrent wr+rd across pointer wrap
      for (int i = 0; i < 5; i++) begin
         wr_i = 1'b1; wr_ch_i = 2'd3; din_i = 16'(16'h3000 + i);
         tick();
      end
      for (int j = 0; j < 20; j++) begin
         wr_i = 1'b1; wr_ch_i = 2'd3; din_i = 16'(16'h3005 + j);
         rd_i = 1'b1; rd_ch_i = 2'd3;
         tick();
         check("wrap_data", 32'(dout_o), 32'(16'h3000 + j));
         check("wrap_vld",  32'(dout_vld_o), 32'h1);
      end
      check("wrap_count3", cnt(3), 32'd5);
      idle();
      tick();

      // flush ch1 with a concurrent write
      for (int i = 0; i < 3; i++) begin
         wr_i = 1'b1; wr_ch_i = 2'd1; din_i = 16'(16'h1100 + i);
         tick();
      end
      check("fl_pre_count1", cnt(1), 32'd3);
      flush_i = 4'b0010; din_i = 16'h1234;
      tick();
      check("fl_count1", cnt(1), 32'd0);
      check("fl_empty1", 32'(empty_o[1]), 32'h1);
      check("fl_noovf",  32'(ovf_o), 32'h0);
      wr_i = 1'b0; rd_i = 1'b1; rd_ch_i = 2'd1;
      tick();
      check("fl_rd_noudf", 32'(udf_o), 32'h0);
      flush_i = 4'b0000;
      tick();
      check("fl_wr_dropped_udf", 32'(udf_o), 32'h1);
      idle();
      wr_i = 1'b1; wr_ch_i = 2'd1; din_i = 16'h5555;
      tick();
      wr_i = 1'b0; rd_i = 1'b1; rd_ch_i = 2'd1;
      tick();
      check("fl_after_data", 32'(dout_o), 32'h5555);
      check("fl_after_cnt",  cnt(1), 32'd0);
      idle();

`ifdef SFIFO_MCHAN_PFULL_EN
      // ch0 holds 1 from the interleave step
      for (int i = 0; i < 4; i++) begin
         wr_i = 1'b1; wr_ch_i = 2'd0; din_i = 16'(16'h0C00 + i);
         tick();
      end
      check("pf_count0_5", cnt(0), 32'd5);
      check("pf_low",      32'(pfull_o[0]), 32'h0);
      tick();
      check("pf_count0_6", cnt(0), 32'd6);
      check("pf_high",     32'(pfull_o[0]), 32'h1);
      idle();
`endif

      // reset mid-traffic with a pending write
      wr_i = 1'b1; wr_ch_i = 2'd0; din_i = 16'hDEAD; rst_i = 1'b1;
      tick();
      rst_i = 1'b0; idle();
      check("mr_count", 32'(count_o), 32'h0);
      check("mr_empty", 32'(empty_o), 32'hF);
      check("mr_full",  32'(full_o), 32'h0);
      check("mr_vld",   32'(dout_vld_o), 32'h0);
      check("mr_dout",  32'(dout_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
